// File: rtl/phase1_sequencer.sv
// Phase 1 stage controller: runs puzzles 1 -> 2 -> 3 via one-hot enables,
// muxes the active puzzle's display onto the board, tracks lives, flashes
// result screens between puzzles and reports phase_done / game_over.
module phase1_sequencer #(
  parameter int FLASH_CYCLES = 50_000_000,
  parameter int MAX_LIVES    = 3,
  parameter int CNT_W        = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        time_up,
  input  logic [15:0] timer_data,
  input  logic [2:0]  p_clear,
  input  logic [2:0]  p_fail,
  input  logic [95:0] p_seg,
  input  logic [23:0] p_led,
  output logic [2:0]  p_enable,
  output logic [31:0] seg_data,
  output logic [7:0]  led_out,
  output logic [2:0]  lives,
  output logic [1:0]  stage,
  output logic        phase_done,
  output logic        game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_OK,
    S_FAIL,
    S_DONE,
    S_OVER
  } state_t;

  localparam logic [2:0]       LIVES_INIT = 3'(MAX_LIVES);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FLASH_CYCLES - 1);

  state_t           state_reg;
  logic [1:0]       stage_reg;
  logic [2:0]       lives_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [31:0] seg_slice [3];
  logic [7:0]  led_slice [3];
  logic [31:0] act_seg;
  logic [7:0]  act_led;
  logic        act_clear;
  logic        act_fail;
  logic        flash_last;

  // Split the packed puzzle buses into per-puzzle words
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_unpack
      assign seg_slice[gi] = p_seg[32*gi +: 32];
      assign led_slice[gi] = p_led[8*gi +: 8];
    end
  endgenerate

  // Pick the data and clear/fail pulses of the puzzle currently selected
  always_comb begin
    act_seg   = seg_slice[0];
    act_led   = led_slice[0];
    act_clear = p_clear[0];
    act_fail  = p_fail[0];
    case (stage_reg)
      2'd1: begin
        act_seg   = seg_slice[1];
        act_led   = led_slice[1];
        act_clear = p_clear[1];
        act_fail  = p_fail[1];
      end
      2'd2: begin
        act_seg   = seg_slice[2];
        act_led   = led_slice[2];
        act_clear = p_clear[2];
        act_fail  = p_fail[2];
      end
      default: ;
    endcase
  end

  // Result screens last exactly FLASH_CYCLES cycles in OK/FAIL
  assign flash_last = (cnt_reg == CNT_LAST);

  // State machine; outputs are registered from the current state, so they
  // trail each state change by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      stage_reg  <= 2'd0;
      lives_reg  <= LIVES_INIT;
      cnt_reg    <= '0;
      p_enable   <= 3'b000;
      seg_data   <= 32'h0;
      led_out    <= 8'h00;
      lives      <= LIVES_INIT;
      stage      <= 2'd0;
      phase_done <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      stage      <= stage_reg;
      lives      <= lives_reg;
      p_enable   <= 3'b000;
      seg_data   <= 32'h0;
      led_out    <= 8'h00;
      phase_done <= 1'b0;
      game_over  <= 1'b0;
      case (state_reg)
        S_RUN: begin
          p_enable <= 3'b001 << stage_reg;
          seg_data <= act_seg;
          led_out  <= act_led;
        end
        S_OK: begin
          seg_data <= {timer_data, 16'h600D};
          led_out  <= 8'hFF;
        end
        S_FAIL: begin
          seg_data <= {timer_data, 16'hFA11};
          led_out  <= 8'hAA;
        end
        S_DONE: begin
          phase_done <= 1'b1;
          seg_data   <= {timer_data, 16'hC1EA};
          led_out    <= 8'h0F;
        end
        S_OVER: begin
          game_over <= 1'b1;
          seg_data  <= 32'hDEADDEAD;
        end
        default: ;
      endcase

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_RUN;
            stage_reg <= 2'd0;
            lives_reg <= LIVES_INIT;
          end
        end
        S_RUN: begin
          // time_up beats clear, clear beats fail
          if (time_up) begin
            state_reg <= S_OVER;
          end else if (act_clear) begin
            state_reg <= S_OK;
            cnt_reg   <= '0;
          end else if (act_fail) begin
            state_reg <= S_FAIL;
            cnt_reg   <= '0;
            lives_reg <= (lives_reg == 3'd0) ? 3'd0 : lives_reg - 3'd1;
          end
        end
        S_OK: begin
          if (time_up) begin
            state_reg <= S_OVER;
          end else if (flash_last) begin
            if (stage_reg == 2'd2) begin
              state_reg <= S_DONE;
            end else begin
              state_reg <= S_RUN;
              stage_reg <= stage_reg + 2'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_FAIL: begin
          // Last life gone: straight to OVER without a flash
          if (time_up || lives_reg == 3'd0) begin
            state_reg <= S_OVER;
          end else if (flash_last) begin
            state_reg <= S_RUN;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_phase1_sequencer.sv
// Bench for phase1_sequencer: directed stimulus pushes hand-computed
// expected output snapshots (tagged with the cycle they must appear on);
// a monitor pops and compares them on the falling edge.
module tb_phase1_sequencer;

  localparam int FC = 8;
  localparam int ML = 3;
  localparam int CW = 4;

  localparam logic [15:0] T = 16'h0930;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        time_up = 1'b0;
  logic [15:0] timer_data = T;
  logic [2:0]  p_clear = 3'b000;
  logic [2:0]  p_fail = 3'b000;
  logic [95:0] p_seg;
  logic [23:0] p_led;
  logic [2:0]  p_enable;
  logic [31:0] seg_data;
  logic [7:0]  led_out;
  logic [2:0]  lives;
  logic [1:0]  stage;
  logic        phase_done;
  logic        game_over;

  assign p_seg = {32'h9ABC0123, 32'h5678BEEF, 32'h1234CAFE};
  assign p_led = {8'h33, 8'h22, 8'h11};

  phase1_sequencer #(
    .FLASH_CYCLES(FC),
    .MAX_LIVES(ML),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .time_up(time_up),
    .timer_data(timer_data),
    .p_clear(p_clear),
    .p_fail(p_fail),
    .p_seg(p_seg),
    .p_led(p_led),
    .p_enable(p_enable),
    .seg_data(seg_data),
    .led_out(led_out),
    .lives(lives),
    .stage(stage),
    .phase_done(phase_done),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic [2:0]  en;
    logic [31:0] seg;
    logic [7:0]  led;
    logic [2:0]  lv;
    logic [1:0]  st;
    logic        dn;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  logic [31:0] run_seg [3] = '{32'h1234CAFE, 32'h5678BEEF, 32'h9ABC0123};
  logic [7:0]  run_led [3] = '{8'h11, 8'h22, 8'h33};

  // posedge counter used to tag expectations
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input int dly, input string nm, input logic [2:0] en,
                     input logic [31:0] seg, input logic [7:0] led,
                     input logic [2:0] lv, input logic [1:0] st,
                     input logic dn, input logic ov);
    exp_t e;
    int   idx;
    e.cyc = cyc + dly; e.name = nm; e.en = en; e.seg = seg; e.led = led;
    e.lv = lv; e.st = st; e.dn = dn; e.ov = ov;
    idx = sb.size();
    while (idx > 0 && sb[idx-1].cyc > e.cyc) idx--;
    sb.insert(idx, e);
  endtask

  task automatic chk_idle(input int dly, input string nm);
    chk(dly, nm, 3'b000, 32'h0, 8'h00, 3'(ML), 2'd0, 1'b0, 1'b0);
  endtask
  task automatic chk_run(input int dly, input string nm, input int st, input logic [2:0] lv);
    chk(dly, nm, 3'b001 << st, run_seg[st], run_led[st], lv, 2'(st), 1'b0, 1'b0);
  endtask
  task automatic chk_ok(input int dly, input string nm, input int st, input logic [2:0] lv);
    chk(dly, nm, 3'b000, {T, 16'h600D}, 8'hFF, lv, 2'(st), 1'b0, 1'b0);
  endtask
  task automatic chk_fail(input int dly, input string nm, input int st, input logic [2:0] lv);
    chk(dly, nm, 3'b000, {T, 16'hFA11}, 8'hAA, lv, 2'(st), 1'b0, 1'b0);
  endtask
  task automatic chk_done(input int dly, input string nm, input int st, input logic [2:0] lv);
    chk(dly, nm, 3'b000, {T, 16'hC1EA}, 8'h0F, lv, 2'(st), 1'b1, 1'b0);
  endtask
  task automatic chk_over(input int dly, input string nm, input int st, input logic [2:0] lv);
    chk(dly, nm, 3'b000, 32'hDEADDEAD, 8'h00, lv, 2'(st), 1'b0, 1'b1);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    chk_idle(0, "reset_vals");
    rst = 1'b0;
  endtask

  // Monitor: compare every expectation due on this cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        vectors++;
        if (e.cyc != cyc || p_enable !== e.en || seg_data !== e.seg ||
            led_out !== e.led || lives !== e.lv || stage !== e.st ||
            phase_done !== e.dn || game_over !== e.ov) begin
          miscompares++;
          $display("FAIL %s cyc=%0d (due %0d): got en=%b seg=%h led=%h lives=%0d stage=%0d done=%b over=%b, expected en=%b seg=%h led=%h lives=%0d stage=%0d done=%b over=%b",
                   e.name, cyc, e.cyc, p_enable, seg_data, led_out, lives, stage,
                   phase_done, game_over, e.en, e.seg, e.led, e.lv, e.st, e.dn, e.ov);
        end else begin
          $display("ok   %s cyc=%0d en=%b seg=%h led=%h lives=%0d stage=%0d",
                   e.name, cyc, p_enable, seg_data, led_out, lives, stage);
        end
      end
    end
  end

  initial begin
    // A: full pass through all three puzzles with one fail on stage 1
    do_reset();
    start = 1'b1; chk_run(2, "start_run0", 0, 3); tick(1); start = 1'b0; tick(1);
    p_clear = 3'b010; chk_run(2, "spurious_clr1", 0, 3); tick(1); p_clear = 3'b000;
    p_clear = 3'b001;
    chk_ok(2, "ok0_first", 0, 3); chk_ok(9, "ok0_last", 0, 3); chk_run(10, "run1", 1, 3);
    tick(1); p_clear = 3'b000; tick(9);
    p_fail = 3'b010;
    chk_fail(2, "fail1_first", 1, 2); chk_fail(9, "fail1_last", 1, 2); chk_run(10, "rerun1", 1, 2);
    tick(1); p_fail = 3'b000; tick(9);
    p_clear = 3'b010; chk_ok(2, "ok1", 1, 2); chk_run(10, "run2", 2, 2);
    tick(1); p_clear = 3'b000; tick(9);
    p_clear = 3'b100; p_fail = 3'b100;
    chk_ok(2, "clr_fail_same", 2, 2); chk_done(10, "done", 2, 2);
    tick(1); p_clear = 3'b000; p_fail = 3'b000; tick(10);
    start = 1'b1; time_up = 1'b1; chk_done(3, "done_hold", 2, 2);
    tick(3); start = 1'b0; time_up = 1'b0; tick(2);

    // B: three fails on stage 0 exhaust the lives
    do_reset();
    start = 1'b1; chk_run(2, "b_start", 0, 3); tick(1); start = 1'b0; tick(1);
    p_fail = 3'b001; chk_fail(2, "b_fail1", 0, 2); chk_run(10, "b_rerun1", 0, 2);
    tick(1); p_fail = 3'b000; tick(9);
    p_fail = 3'b001; chk_fail(2, "b_fail2", 0, 1); chk_run(10, "b_rerun2", 0, 1);
    tick(1); p_fail = 3'b000; tick(9);
    p_fail = 3'b001; chk_fail(2, "b_fail3", 0, 0); chk_over(3, "b_over", 0, 0);
    chk_over(8, "b_over_hold", 0, 0);
    tick(1); p_fail = 3'b000; tick(9);

    // C: time_up wins over a same-cycle clear
    do_reset();
    start = 1'b1; tick(1); start = 1'b0; tick(1);
    time_up = 1'b1; p_clear = 3'b001; chk_over(2, "tu_vs_clr", 0, 3);
    tick(1); time_up = 1'b0; p_clear = 3'b000; tick(3);

    // D: time_up ignored in IDLE, then async reset in the middle of OK
    do_reset();
    time_up = 1'b1; chk_idle(3, "tu_idle"); tick(3); time_up = 1'b0;
    start = 1'b1; tick(1); start = 1'b0; tick(1);
    p_clear = 3'b001; chk_ok(2, "d_ok", 0, 3); tick(1); p_clear = 3'b000; tick(3);
    rst = 1'b1; chk_idle(0, "rst_mid_ok"); tick(1); rst = 1'b0; tick(2);

    // drain outstanding expectations, bounded
    for (int i = 0; i < 40 && sb.size() > 0; i++) tick(1);
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
